// File: rtl/led_driver_pkg.sv
// Shared types and constants for the multi-channel LED driver.
package led_driver_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    localparam int unsigned PERIOD_W = 16;

    // Terminal count of the clock-to-tick prescaler.
    function automatic int unsigned prescale_tc(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/level/period registers, step timing and registered drive.
// BREATHE mode exists only when LED_DRIVER_BREATHE_EN is defined; otherwise mode 4 is OFF.
module led_channel
    import led_driver_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                we_i,
    input  logic [2:0]          cfg_mode_i,
    input  logic [PWM_BITS-1:0] cfg_level_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    output logic                led_o
);

    logic [2:0]          mode_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_q;
    logic                led_q;
    logic                led_d;
    logic [PERIOD_W-1:0] last_cnt;
    logic                step;

    // A period of 0 is run as a period of 1.
    always_comb begin
        last_cnt = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
        step     = tick_i && (cnt_q == last_cnt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= MODE_OFF;
            level_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            if (we_i) begin
                mode_q   <= cfg_mode_i;
                level_q  <= cfg_level_i;
                period_q <= cfg_period_i;
                cnt_q    <= '0;
                phase_q  <= 1'b0;
            end else begin
                if (tick_i) begin
                    cnt_q <= step ? '0 : cnt_q + PERIOD_W'(1);
                end
                if (step) begin
                    phase_q <= ~phase_q;
                end
            end
            led_q <= led_d;
        end
    end

`ifdef LED_DRIVER_BREATHE_EN
    logic [PWM_BITS-1:0] value_q;
    logic                down_q;

    // Triangle walk 0 -> max -> 0; direction flips on the step that reaches an end.
    always_ff @(posedge clk_i) begin
        if (rst_i || we_i) begin
            value_q <= '0;
            down_q  <= 1'b0;
        end else if (step) begin
            if (down_q) begin
                value_q <= value_q - PWM_BITS'(1);
                if (value_q == PWM_BITS'(1)) begin
                    down_q <= 1'b0;
                end
            end else begin
                value_q <= value_q + PWM_BITS'(1);
                if (value_q == {{(PWM_BITS-1){1'b1}}, 1'b0}) begin
                    down_q <= 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_ON:      led_d = 1'b1;
            MODE_BLINK:   led_d = phase_q;
            MODE_PWM:     led_d = pwm_cnt_i < level_q;
`ifdef LED_DRIVER_BREATHE_EN
            MODE_BREATHE: led_d = pwm_cnt_i < value_q;
`endif
            default:      led_d = 1'b0;
        endcase
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_driver.sv
// Multi-channel LED driver top: shared tick prescaler, shared PWM counter, cfg_ch decode.
// Optional BREATHE mode is enabled by defining LED_DRIVER_BREATHE_EN.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned NCH      = 4,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                                  clk50mhz,
    input  logic                                  reset,
    input  logic                                  cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [2:0]                            cfg_mode,
    input  logic [PWM_BITS-1:0]                   cfg_level,
    input  logic [PERIOD_W-1:0]                   cfg_period,
    output logic [NCH-1:0]                        led
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TC    = prescale_tc(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W = (TC > 0) ? $clog2(TC + 1) : 1;

    if (CLK_HZ / TICK_HZ < 2) begin : g_bad_div
        $error("led_driver: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("led_driver: NCH must be in 1..16");
    end

    logic [PRE_W-1:0]    pre_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                tick;
    logic [NCH-1:0]      we_ch;

    assign tick = (pre_q == PRE_W'(TC));

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    // Out-of-range channel numbers match no index and are dropped.
    always_comb begin
        we_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk_i        (clk50mhz),
            .rst_i        (reset),
            .tick_i       (tick),
            .pwm_cnt_i    (pwm_q),
            .we_i         (we_ch[g]),
            .cfg_mode_i   (cfg_mode),
            .cfg_level_i  (cfg_level),
            .cfg_period_i (cfg_period),
            .led_o        (led[g])
        );
    end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: directed scenarios plus random configuration traffic
// compared cycle by cycle against a tick/step arithmetic model.
module tb_led_driver;

    localparam int NCH      = 4;
    localparam int PWM_BITS = 4;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int PWM_N    = 1 << PWM_BITS;
    localparam int VMAX     = PWM_N - 1;

    logic           clk50mhz = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [2:0]     cfg_mode = '0;
    logic [3:0]     cfg_level = '0;
    logic [15:0]    cfg_period = '0;
    logic [NCH-1:0] led;

    int n_checks = 0;
    int n_errors = 0;

    led_driver #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .NCH      (NCH),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk50mhz   (clk50mhz),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_level  (cfg_level),
        .cfg_period (cfg_period),
        .led        (led)
    );

    always #5 clk50mhz = ~clk50mhz;

    // Model: per channel, the configuration and the number of ticks seen since its last write.
    int             m_mode[NCH];
    int             m_level[NCH];
    int             m_period[NCH];
    int             m_ticks[NCH];
    int             cyc;
    logic [NCH-1:0] exp_led;

    task automatic check(input string tag, input logic [NCH-1:0] got,
                         input logic [NCH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic logic model_led(input int c, input int pwm);
        int steps;
        int s;
        steps = m_ticks[c] / m_period[c];
        case (m_mode[c])
            1: return 1'b1;
            2: return logic'(steps % 2);
            3: return pwm < m_level[c];
`ifdef LED_DRIVER_BREATHE_EN
            4: begin
                s = steps % (2 * VMAX);
                return pwm < ((s <= VMAX) ? s : 2 * VMAX - s);
            end
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        int  pwm;
        bit  tick;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_level[c] = 0; m_period[c] = 1; m_ticks[c] = 0;
            end
            cyc     = 0;
            exp_led = '0;
            return;
        end
        pwm  = cyc % PWM_N;
        tick = (cyc % DIV) == DIV - 1;
        for (int c = 0; c < NCH; c++) exp_led[c] = model_led(c, pwm);
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c]   = int'(cfg_mode);
                m_level[c]  = int'(cfg_level);
                m_period[c] = (cfg_period == 0) ? 1 : int'(cfg_period);
                m_ticks[c]  = 0;
            end else if (tick) begin
                m_ticks[c]++;
            end
        end
        cyc++;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk50mhz);
        #1;
        check(tag, led, exp_led);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic write(input int ch, input int mode, input int level, input int period,
                         input string tag);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_mode   = 3'(mode);
        cfg_level  = 4'(level);
        cfg_period = 16'(period);
        cycle(tag);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n, "reset");
        reset = 1'b0;
    endtask

    initial begin
        do_reset(3);
        check("reset_led", led, '0);

        // First tick lands on the 10th edge after release; a period-1 blink exposes it.
        write(0, 2, 0, 1, "tick_blink_wr");
        idle(25, "tick_blink");
        write(0, 0, 0, 0, "tick_blink_off");

        write(2, 1, 0, 0, "on_wr");
        idle(3, "on");
        write(2, 0, 0, 0, "off_wr");
        idle(3, "off");

        write(0, 2, 0, 3, "blink3_wr");
        idle(130, "blink3");
        write(0, 2, 0, 0, "blink0_wr");
        idle(45, "blink0");

        write(1, 3, 5, 0, "pwm5_wr");
        idle(48, "pwm5");
        write(1, 3, 0, 0, "pwm0_wr");
        idle(32, "pwm0");
        write(1, 3, 15, 0, "pwm15_wr");
        idle(48, "pwm15");

        write(3, 4, 0, 1, "breathe_wr");
        idle(620, "breathe");

        write(0, 6, 9, 2, "mode6_wr");
        idle(12, "mode6");

        // Write on the very edge where a step would fire: channel must restart cleared.
        write(0, 2, 0, 1, "coinc_setup");
        idle(12, "coinc_run");
        while ((cyc % DIV) != DIV - 1) cycle("coinc_align");
        write(0, 2, 0, 1, "coinc_wr");
        idle(25, "coinc_after");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
                check("mid_reset", led, '0);
            end else if ($urandom_range(0, 7) == 0) begin
                write($urandom_range(0, NCH - 1), $urandom_range(0, 7),
                      $urandom_range(0, VMAX), $urandom_range(0, 4), "rand_wr");
            end else begin
                cycle("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
